// File: rtl/be8_control_sequencer_pkg.sv
// Shared definitions for the BE8 control path: control-word constants, bit
// positions within the 18-bit word, phase encoding and opcode numbers.
package be8_ctrl_pkg;

    localparam int CW_W = 18;

    // Active-low bits parked high, active-high bits low.
    localparam logic [CW_W-1:0] CW_IDLE = 18'h07F7F;
    localparam logic [CW_W-1:0] CW_F0   = 18'h07E77;
    localparam logic [CW_W-1:0] CW_F1   = 18'h1777D;

    localparam int HLT_BIT = 17;
    localparam int CE_BIT  = 16;
    localparam int SU_BIT  = 15;
    localparam int AIN_BIT = 14;
    localparam int BIN_BIT = 13;
    localparam int OIN_BIT = 12;
    localparam int IIN_BIT = 11;
    localparam int JN_BIT  = 10;
    localparam int FIN_BIT = 9;
    localparam int MIN_BIT = 8;
    localparam int RI_BIT  = 7;
    localparam int AON_BIT = 6;
    localparam int BON_BIT = 5;
    localparam int ION_BIT = 4;
    localparam int CON_BIT = 3;
    localparam int EON_BIT = 2;
    localparam int RON_BIT = 1;
    localparam int NON_BIT = 0;

    typedef enum logic [1:0] {
        PH_FETCH0 = 2'd0,
        PH_FETCH1 = 2'd1,
        PH_EXEC   = 2'd2,
        PH_HALT   = 2'd3
    } phase_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

endpackage

// File: rtl/be8_control_sequencer_step_gate.sv
// Advance gate: free-run when RUN is high, otherwise one advance per rising
// edge of the STEP_REQ level.
module be8_step_gate
    import be8_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ena,
    input  logic i_run,
    input  logic i_step_req,
    output logic o_adv
);

    logic r_step_req_q;
    logic w_step_rise;

    // Previous STEP_REQ level only moves on enabled cycles so a request held
    // across a frozen period is not seen as a new edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step_req_q <= 1'b0;
        end else if (i_ena) begin
            r_step_req_q <= i_step_req;
        end
    end

    assign w_step_rise = i_step_req & ~r_step_req_q;
    assign o_adv       = i_ena & (i_run | (~i_run & w_step_rise));

endmodule

// File: rtl/be8_control_sequencer.sv
// BE8 control sequencer: fetch phases, exec microstep counter, opcode and
// flag latches, and selection of the control word driven to the datapath.
module be8_control_sequencer
    import be8_ctrl_pkg::*;
#(
    parameter bit EARLY_END  = 1'b1,
    parameter int EXEC_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        RUN,
    input  logic        STEP_REQ,
    input  logic [7:0]  BUS_IN,
    input  logic        ALU_C,
    input  logic        ALU_Z,
    input  logic [17:0] UC_WORD,
    output logic [3:0]  OPCODE,
    output logic [1:0]  FLAGS,
    output logic [1:0]  STEP,
    output logic [17:0] CTRL,
    output logic        HALTED,
    output logic        INSTR_DONE,
    output logic [1:0]  PHASE
);

    localparam logic [1:0] LAST_STEP = 2'(EXEC_STEPS - 1);

    phase_e      r_state;
    phase_e      w_next_state;
    logic [1:0]  r_step;
    logic [1:0]  w_next_step;
    logic [3:0]  r_opcode;
    logic [1:0]  r_flags;
    logic        r_instr_done;
    logic [17:0] w_ctrl;
    logic        w_ends_instr;
    logic        w_adv;
    logic        w_bus_low_unused;

    be8_step_gate u_step_gate (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ena      (ena),
        .i_run      (RUN),
        .i_step_req (STEP_REQ),
        .o_adv      (w_adv)
    );

    // HLT wins over early termination, which wins over the step limit.
    always_comb begin
        w_ctrl       = CW_IDLE;
        w_next_state = r_state;
        w_next_step  = 2'd0;
        w_ends_instr = 1'b0;
        case (r_state)
            PH_FETCH0: begin
                w_ctrl       = CW_F0;
                w_next_state = PH_FETCH1;
            end
            PH_FETCH1: begin
                w_ctrl       = CW_F1;
                w_next_state = PH_EXEC;
            end
            PH_EXEC: begin
                w_ctrl = UC_WORD;
                if (UC_WORD[HLT_BIT]) begin
                    w_next_state = PH_HALT;
                end else if (EARLY_END && (UC_WORD == CW_IDLE)) begin
                    w_next_state = PH_FETCH0;
                    w_ends_instr = 1'b1;
                end else if (r_step == LAST_STEP) begin
                    w_next_state = PH_FETCH0;
                    w_ends_instr = 1'b1;
                end else begin
                    w_next_step  = r_step + 2'd1;
                end
            end
            default: begin
                w_ctrl       = CW_IDLE;
                w_next_state = PH_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PH_FETCH0;
            r_step       <= 2'd0;
            r_opcode     <= 4'd0;
            r_flags      <= 2'd0;
            r_instr_done <= 1'b0;
        end else begin
            if (ena) begin
                r_instr_done <= w_adv & w_ends_instr;
            end
            if (w_adv) begin
                r_state <= w_next_state;
                r_step  <= w_next_step;
                if (!w_ctrl[IIN_BIT]) begin
                    r_opcode <= BUS_IN[7:4];
                end
                if (!w_ctrl[FIN_BIT]) begin
                    r_flags <= {ALU_C, ALU_Z};
                end
            end
        end
    end

    assign w_bus_low_unused = ^BUS_IN[3:0];

    assign CTRL       = w_ctrl;
    assign OPCODE     = r_opcode;
    assign FLAGS      = r_flags;
    assign STEP       = (r_state == PH_EXEC) ? r_step : 2'd0;
    assign HALTED     = (r_state == PH_HALT);
    assign INSTR_DONE = r_instr_done;
    assign PHASE      = r_state;

endmodule

// File: tb/tb_be8_control_sequencer.sv
// Scoreboard bench for be8_control_sequencer: directed stimulus queues
// expected values keyed by cycle, a negedge monitor pops and compares.
module tb_be8_control_sequencer;

    localparam logic [17:0] TB_IDLE = 18'h07F7F;
    localparam logic [17:0] TB_F0   = 18'h07E77;
    localparam logic [17:0] TB_F1   = 18'h1777D;

    localparam int F_CTRL   = 0;
    localparam int F_PHASE  = 1;
    localparam int F_STEP   = 2;
    localparam int F_OPCODE = 3;
    localparam int F_FLAGS  = 4;
    localparam int F_HALTED = 5;
    localparam int F_DONE   = 6;
    localparam int F_PHASE2 = 7;
    localparam int F_STEP2  = 8;
    localparam int F_DONE2  = 9;
    localparam int F_CTRL2  = 10;
    localparam int F_FLAGS2 = 11;
    localparam int F_HALT2  = 12;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        run;
    logic        stepReq;
    logic [7:0]  busIn;
    logic        aluC;
    logic        aluZ;
    logic [17:0] ucWord;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic [1:0]  step;
    logic [17:0] ctrl;
    logic        halted;
    logic        instrDone;
    logic [1:0]  phase;

    logic [17:0] ucWord2;
    logic [3:0]  opcode2;
    logic [1:0]  flags2;
    logic [1:0]  step2;
    logic [17:0] ctrl2;
    logic        halted2;
    logic        instrDone2;
    logic [1:0]  phase2;

    int  cyc;
    int  checks;
    int  errors;
    sb_t sbQ[$];

    be8_control_sequencer #(.EARLY_END(1'b1), .EXEC_STEPS(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .RUN        (run),
        .STEP_REQ   (stepReq),
        .BUS_IN     (busIn),
        .ALU_C      (aluC),
        .ALU_Z      (aluZ),
        .UC_WORD    (ucWord),
        .OPCODE     (opcode),
        .FLAGS      (flags),
        .STEP       (step),
        .CTRL       (ctrl),
        .HALTED     (halted),
        .INSTR_DONE (instrDone),
        .PHASE      (phase)
    );

    be8_control_sequencer #(.EARLY_END(1'b0), .EXEC_STEPS(4)) u_dut_full (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .RUN        (run),
        .STEP_REQ   (stepReq),
        .BUS_IN     (busIn),
        .ALU_C      (aluC),
        .ALU_Z      (aluZ),
        .UC_WORD    (ucWord2),
        .OPCODE     (opcode2),
        .FLAGS      (flags2),
        .STEP       (step2),
        .CTRL       (ctrl2),
        .HALTED     (halted2),
        .INSTR_DONE (instrDone2),
        .PHASE      (phase2)
    );

    // Small microcode ROM covering the opcodes the bench exercises.
    function automatic logic [17:0] romModel(input logic [3:0] op, input logic [1:0] st);
        logic [17:0] w;
        w = TB_IDLE;
        case (op)
            4'd1: begin
                if (st == 2'd0) w = 18'h07337;
                else if (st == 2'd1) w = 18'h03F7D;
            end
            4'd2: begin
                if (st == 2'd0) w = 18'h07E6F;
                else if (st == 2'd1) w = 18'h05F7D;
                else if (st == 2'd2) w = 18'h0397B;
            end
            4'd6: begin
                if (st == 2'd0) w = 18'h07B6F;
            end
            4'd15: begin
                if (st == 2'd0) w = 18'h27F7F;
            end
            default: w = TB_IDLE;
        endcase
        return w;
    endfunction

    always_comb ucWord  = romModel(opcode, step);
    always_comb ucWord2 = romModel(opcode2, step2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] getField(input int sel);
        case (sel)
            F_CTRL:   return 32'(ctrl);
            F_PHASE:  return 32'(phase);
            F_STEP:   return 32'(step);
            F_OPCODE: return 32'(opcode);
            F_FLAGS:  return 32'(flags);
            F_HALTED: return 32'(halted);
            F_DONE:   return 32'(instrDone);
            F_PHASE2: return 32'(phase2);
            F_STEP2:  return 32'(step2);
            F_DONE2:  return 32'(instrDone2);
            F_CTRL2:  return 32'(ctrl2);
            F_FLAGS2: return 32'(flags2);
            F_HALT2:  return 32'(halted2);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input sb_t item);
        logic [31:0] act;
        act = getField(item.sel);
        checks++;
        if (item.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL %s stale entry for cycle %0d seen at cycle %0d", item.name, item.cyc, cyc);
        end else if (act !== item.exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got 0x%0h expected 0x%0h", item.name, cyc, act, item.exp);
        end
    endtask

    // Monitor: every negedge, compare all entries due for this cycle.
    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            checkOutput(sbQ.pop_front());
        end
    end

    task automatic expectAt(input int ofs, input string name, input int sel, input logic [31:0] val);
        sb_t item;
        int  idx;
        item.cyc  = cyc + ofs;
        item.name = name;
        item.sel  = sel;
        item.exp  = val;
        idx = sbQ.size();
        while (idx > 0 && sbQ[idx-1].cyc > item.cyc) idx--;
        sbQ.insert(idx, item);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic rn,
                                 input logic sr, input logic [7:0] bus);
        rst     = r;
        ena     = en;
        run     = rn;
        stepReq = sr;
        busIn   = bus;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        aluC   = 1'b0;
        aluZ   = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);

        // Reset held two cycles with an opcode-looking bus value.
        waitCycle();
        waitCycle();
        expectAt(0, "rst_ctrl", F_CTRL, 32'(TB_F0));
        expectAt(0, "rst_step", F_STEP, 0);
        expectAt(0, "rst_opcode", F_OPCODE, 0);
        expectAt(0, "rst_flags", F_FLAGS, 0);
        expectAt(0, "rst_halted", F_HALTED, 0);
        expectAt(0, "rst_phase", F_PHASE, 0);
        expectAt(0, "rst_done", F_DONE, 0);

        // LDA: full control-word sequence queued up front.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h1E);
        expectAt(0, "lda_f0", F_CTRL, 32'(TB_F0));
        expectAt(1, "lda_f1", F_CTRL, 32'(TB_F1));
        expectAt(1, "lda_f1_op", F_OPCODE, 0);
        expectAt(2, "lda_e0", F_CTRL, 32'h07337);
        expectAt(2, "lda_e0_op", F_OPCODE, 1);
        expectAt(2, "lda_e0_ph", F_PHASE, 2);
        expectAt(3, "lda_e1", F_CTRL, 32'h03F7D);
        expectAt(3, "lda_e1_step", F_STEP, 1);
        expectAt(4, "lda_e2", F_CTRL, 32'(TB_IDLE));
        expectAt(4, "lda_e2_done", F_DONE, 0);
        expectAt(5, "lda_end_done", F_DONE, 1);
        expectAt(5, "lda_end_ph", F_PHASE, 0);
        expectAt(5, "lda_end_step", F_STEP, 0);
        repeat (5) waitCycle();

        // ADD: flags only latch on the FIn step.
        busIn = 8'h25; aluC = 1'b1; aluZ = 1'b1;
        expectAt(0, "add_f0_flags", F_FLAGS, 0);
        waitCycle();
        expectAt(0, "add_f1_flags", F_FLAGS, 0);
        expectAt(0, "add_f1_done", F_DONE, 0);
        waitCycle();
        expectAt(0, "add_e0_op", F_OPCODE, 2);
        expectAt(0, "add_e0_flags", F_FLAGS, 0);
        aluC = 1'b1; aluZ = 1'b0;
        waitCycle();
        expectAt(0, "add_e1_flags", F_FLAGS, 0);
        waitCycle();
        expectAt(0, "add_e2_ctrl", F_CTRL, 32'h0397B);
        expectAt(0, "add_e2_flags", F_FLAGS, 0);
        waitCycle();
        expectAt(0, "add_e3_flags", F_FLAGS, 2);
        expectAt(0, "add_e3_step", F_STEP, 3);
        aluC = 1'b0; aluZ = 1'b1;
        waitCycle();
        expectAt(0, "add_end_done", F_DONE, 1);
        expectAt(0, "add_end_flags", F_FLAGS, 2);
        waitCycle();
        expectAt(0, "add_hold_flags", F_FLAGS, 2);

        // Clock enable low freezes everything in FETCH1.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h1E);
        repeat (3) waitCycle();
        expectAt(0, "ena_phase", F_PHASE, 1);
        expectAt(0, "ena_ctrl", F_CTRL, 32'(TB_F1));
        expectAt(0, "ena_opcode", F_OPCODE, 2);

        // Reset in the middle of exec step 1.
        ena = 1'b1;
        waitCycle();
        waitCycle();
        expectAt(0, "mid_step", F_STEP, 1);
        expectAt(0, "mid_phase", F_PHASE, 2);
        rst = 1'b1;
        waitCycle();
        expectAt(0, "midrst_phase", F_PHASE, 0);
        expectAt(0, "midrst_opcode", F_OPCODE, 0);
        expectAt(0, "midrst_flags", F_FLAGS, 0);
        expectAt(0, "midrst_step", F_STEP, 0);

        // Single-step: three separate pulses.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h1E);
        waitCycle();
        expectAt(0, "ss_idle_phase", F_PHASE, 0);
        stepReq = 1'b1; waitCycle(); stepReq = 1'b0;
        expectAt(0, "ss_p1_phase", F_PHASE, 1);
        waitCycle();
        expectAt(0, "ss_p1_hold", F_PHASE, 1);
        stepReq = 1'b1; waitCycle(); stepReq = 1'b0; waitCycle();
        stepReq = 1'b1; waitCycle(); stepReq = 1'b0; waitCycle();
        expectAt(0, "ss_p3_phase", F_PHASE, 2);
        expectAt(0, "ss_p3_step", F_STEP, 1);
        expectAt(0, "ss_p3_opcode", F_OPCODE, 1);

        // Level held high five cycles: exactly one advance.
        stepReq = 1'b1;
        waitCycle();
        expectAt(0, "ss_hold1_step", F_STEP, 2);
        repeat (4) waitCycle();
        expectAt(0, "ss_hold5_phase", F_PHASE, 2);
        expectAt(0, "ss_hold5_step", F_STEP, 2);
        expectAt(0, "ss_hold5_ctrl", F_CTRL, 32'(TB_IDLE));
        stepReq = 1'b0;

        // HLT: one exec cycle with HLT set, then parked until reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hF0);
        waitCycle();
        expectAt(0, "hlt_f0_done", F_DONE, 1);
        waitCycle();
        waitCycle();
        expectAt(0, "hlt_exec_ctrl", F_CTRL, 32'h27F7F);
        expectAt(0, "hlt_exec_op", F_OPCODE, 15);
        waitCycle();
        expectAt(0, "hlt_halted", F_HALTED, 1);
        expectAt(0, "hlt_phase", F_PHASE, 3);
        for (int i = 0; i < 20; i++) begin
            stepReq = ~stepReq;
            waitCycle();
            expectAt(0, "hlt_park_phase", F_PHASE, 3);
            expectAt(0, "hlt_park_ctrl", F_CTRL, 32'(TB_IDLE));
        end
        rst = 1'b1;
        waitCycle();
        expectAt(0, "hlt_rst_phase", F_PHASE, 0);
        expectAt(0, "hlt_rst_halted", F_HALTED, 0);
        expectAt(0, "hlt_rst_ctrl", F_CTRL, 32'(TB_F0));

        // NOP stream: early-end instance 3 cycles, full-length instance 6.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        expectAt(0, "full_flags", F_FLAGS2, 0);
        expectAt(0, "full_halted", F_HALT2, 0);
        expectAt(2, "full_e0_ctrl", F_CTRL2, 32'(TB_IDLE));
        for (int k = 0; k <= 12; k++) begin
            int ph;
            ph = k % 6;
            expectAt(k, "full_phase", F_PHASE2, (ph == 0) ? 0 : (ph == 1) ? 1 : 2);
            expectAt(k, "full_step", F_STEP2, (ph >= 2) ? ph - 2 : 0);
            expectAt(k, "full_done", F_DONE2, (k == 6 || k == 12) ? 1 : 0);
        end
        expectAt(2, "nop_e0_phase", F_PHASE, 2);
        expectAt(3, "nop_done", F_DONE, 1);
        expectAt(4, "nop_done_clr", F_DONE, 0);
        expectAt(6, "nop_done2", F_DONE, 1);
        repeat (12) waitCycle();

        for (int t = 0; t < 50 && sbQ.size() > 0; t++) waitCycle();
        if (sbQ.size() > 0) begin
            errors += sbQ.size();
            $display("[TB] FAIL drain %0d entries left, expected 0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time %0t limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
